seg_scan_controller: RTL
========================

Name: seg_scan_controller

Overview:
- Time-multiplexes four hex digits (adder sum plus carry/dp) onto the shared 4-anode seven-segment display.
- Rotates the active anode at a fixed refresh rate and inserts a blanking gap between digits to prevent ghosting.
- Takes new display values through a req/ack handshake, applied only at frame boundaries so a frame never tears.
- Sits between the arithmetic datapath and the board display pins; it replaces static anode selection.

Parameters:
- PRESCALE, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz). Must satisfy PRESCALE > BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be ≥ 1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scan display; 0 = display dark.
- digit_data  input  20  four 5-bit digits. Digit i = digit_data[5i+4:5i]; bit 4 = dp, bits 3:0 = hex value. Digit 0 is rightmost.
- update_req  input  1  level request to load digit_data. Requester holds data stable while req is high until ack.
- update_ack  output  1  one-cycle pulse: digit_data captured into shadow registers.
- blank_lz  input  1  1 = leading-zero blanking on.
- seg_n  output  7  segments a..g, active-low (bit0 = a).
- dp_n  output  1  decimal point, active-low.
- an_n  output  4  anodes, active-low; an_n[i] drives digit i.
- frame_tick  output  1  one-cycle pulse at the end of every completed 4-digit frame.

Behaviour:
- Reset (async, rst_n = 0) forces:
  - state IDLE, digit index 0, slot counter 0, shadow registers 0;
  - an_n = 4'b1111, seg_n = 7'h7F, dp_n = 1, update_ack = 0, frame_tick = 0.
  - Reset mid-frame or mid-handshake aborts immediately; no ack is issued for a pending req.
- States: IDLE, BLANK, DRIVE.
  - IDLE:
    - All outputs dark.
    - If enable = 1, go to BLANK with index 0 and counter 0 on the next edge.
  - BLANK:
    - an_n = 1111, seg_n = 7'h7F, dp_n = 1.
    - Counter counts to BLANK_CYCLES−1, then go to DRIVE.
  - DRIVE:
    - an_n[idx] = 0 (others 1); seg_n and dp_n show shadow digit idx.
    - Lasts PRESCALE−BLANK_CYCLES cycles, then go to BLANK with idx+1.
    - idx wraps 3→0.
- Slot length is exactly PRESCALE cycles. Frame length is 4×PRESCALE cycles.
- frame_tick pulses in the last DRIVE cycle of idx 3.
- enable = 0 in any state: go to IDLE next edge and go dark. Index and counter reset to 0.
- All display outputs are registered; one cycle of latency from the state to the pins.
- Hex decode uses standard patterns. Examples (active-high gfedcba): 0 = 0111111, 8 = 1111111, F = 1110001, b = 1111100. seg_n is the inverse.
- Leading-zero blanking (blank_lz = 1):
  - Digit i (i = 3..1) is blanked (seg_n = 7'h7F) when its value and all higher digits' values are 0.
  - Digit 0 is never blanked.
  - dp is not affected by blanking.
  - The anode is still driven for a blanked digit, keeping uniform timing.
- Update handshake:
  - When enabled, update_req = 1 is sampled in the frame_tick cycle. Shadow registers load on that edge, and update_ack = 1 the following cycle.
  - In IDLE, update_req is accepted on the first cycle seen: load, then ack next cycle.
  - update_req must be deasserted within one cycle of ack. A req still high two cycles after ack counts as a new request.
  - Changing digit_data while req = 1 before ack is illegal.
  - Simultaneous enable rise and req in IDLE: the load happens, and the first frame shows the new data.
- The counter and index never exceed their ranges. No other timing-dependent wrap exists.

Test Plan (PRESCALE = 8, BLANK_CYCLES = 2 unless noted):
- Reset: assert rst_n = 0 mid-DRIVE → an_n = 1111, seg_n = 7F, dp_n = 1, update_ack = 0 asynchronously. Release with enable = 1 → first DRIVE on an_n = 1110 begins 2 cycles after the first BLANK cycle.
- Scan timing: enable = 1, shadow = 0x0_8_F_1 (digits 3..0) → each anode low for 6 cycles after 2 dark cycles. Sequence is 1110, 1101, 1011, 0111. frame_tick every 32 cycles. Digit 1 seg_n = 0001110 (F). Digit 2 seg_n = 0000000 (8).
- Handshake: req = 1 with digit_data = {5'h10, 5'h03, 5'h0A, 5'h05} mid-frame → no ack until the frame_tick cycle; ack exactly 1 cycle later. The new values appear from the next frame's digit 0. Digit 3 shows dp_n = 0 and seg_n for 0.
- Leading-zero blanking: blank_lz = 1, digits 3..0 = 0, 0, 1, 0 → digits 3 and 2 seg_n = 7F, digit 1 shows 1, digit 0 shows 0. With all digits 0 → only digit 0 lit.
- Disable mid-frame: drop enable during DRIVE of idx 2 → dark on the next registered cycle. Re-enable → restarts at idx 0 BLANK. A pending req while disabled is acked 2 cycles after being seen.
- Boundary: BLANK_CYCLES = 1, PRESCALE = 2 → 1 dark cycle and 1 lit cycle per slot. Index wraps 3→0 without a skipped or extra slot across 3 frames.

Source files
------------

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes four hex digits onto a 4-anode seven-segment display,
// with a dark gap at the start of every slot and frame-synchronous req/ack shadow loading.
`default_nettype none
module seg_scan_controller #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [19:0] digit_data,
  input  logic        update_req,
  output logic        update_ack,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);
  localparam int            CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   shadow_q;
  logic          ack_hold_q;
  logic          load;
  logic [4:0]    cur;
  logic [3:0]    zero;
  logic          lz_blank;
  logic [6:0]    pat;
  logic          drive;

  // The counter spans the whole slot: BLANK covers the first BLANK_CYCLES counts, DRIVE the rest.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
        BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  assign frame_tick = (state_q == DRIVE) && (idx_q == 2'd3) && (cnt_q == SLOT_LAST);
  // Requests are taken only at a frame boundary or while idle; the two cycles around ack are ignored.
  assign load = update_req && !update_ack && !ack_hold_q && (frame_tick || state_q == IDLE);

  always_comb begin
    zero[0] = (shadow_q[3:0]   == 4'h0);
    zero[1] = (shadow_q[8:5]   == 4'h0);
    zero[2] = (shadow_q[13:10] == 4'h0);
    zero[3] = (shadow_q[18:15] == 4'h0);
    cur      = shadow_q[4:0];
    lz_blank = 1'b0;
    case (idx_q)
      2'd0: cur = shadow_q[4:0];
      2'd1: begin cur = shadow_q[9:5];   lz_blank = zero[3] & zero[2] & zero[1]; end
      2'd2: begin cur = shadow_q[14:10]; lz_blank = zero[3] & zero[2]; end
      2'd3: begin cur = shadow_q[19:15]; lz_blank = zero[3]; end
      default: cur = shadow_q[4:0];
    endcase
    case (cur[3:0])
      4'h0: pat = 7'h3F;  4'h1: pat = 7'h06;  4'h2: pat = 7'h5B;  4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;  4'h5: pat = 7'h6D;  4'h6: pat = 7'h7D;  4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;  4'h9: pat = 7'h6F;  4'hA: pat = 7'h77;  4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;  4'hD: pat = 7'h5E;  4'hE: pat = 7'h79;  4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    drive = enable && (state_q == DRIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      shadow_q   <= '0;
      update_ack <= 1'b0;
      ack_hold_q <= 1'b0;
      an_n       <= 4'b1111;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      update_ack <= load;
      ack_hold_q <= update_ack;
      if (load) shadow_q <= digit_data;
      an_n  <= drive ? ~(4'b0001 << idx_q) : 4'b1111;
      seg_n <= (drive && !(blank_lz && lz_blank)) ? ~pat : 7'h7F;
      dp_n  <= drive ? ~cur[4] : 1'b1;
    end
  end
endmodule
`default_nettype wire
